seg7_scan_driver: RTL



---
 rtl/seg7_scan_driver_pkg.sv | 38 +++
 rtl/seg7_hex_decode.sv | 39 +++
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_pkg
// Description : Shared constants for the multiplexed seven-segment driver:
//               active-low segment codes (bit 6 = a .. bit 0 = g) for the hex
//               characters 0..F, the dark pattern and the mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_scan_driver_pkg;

    // Segment patterns, active-low, ordered a b c d e f g (MSB = a)
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b1110010;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Display mode select
    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_SCROLL = 1'b1;

    // One displayable character
    typedef logic [3:0] char_t;

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational 4-bit hex character to active-low 7-segment
//               pattern decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] char_i,
    output logic [6:0] seg_o
);

    // Character lookup; every code is listed so the default never survives
    always_comb begin
        seg_o = SEG_BLANK;
        case (char_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed common-anode seven-segment driver. Shows
//               either a parallel static character bus or a rotating window
//               over a writable scroll message. Digit enables, segments and
//               decimal point are registered together so they never glitch
//               against each other.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int MSG_LEN     = 16,
    parameter int SCROLL_DIV  = 25000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode,
    input  logic [4*NUM_DIGITS-1:0]    dataIn,
    input  logic [NUM_DIGITS-1:0]      blank,
    input  logic [NUM_DIGITS-1:0]      dp,
    input  logic                       wrEn,
    input  logic [$clog2(MSG_LEN)-1:0] wrAddr,
    input  logic [3:0]                 wrData,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [6:0]                 LED,
    output logic                       dpOut,
    output logic [$clog2(MSG_LEN)-1:0] scrollPos
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int AW = $clog2(MSG_LEN);
    localparam int SW = $clog2(SCROLL_DIV);

    localparam logic [CW-1:0] C_CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] C_DEAD     = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] C_IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0] C_SC_LAST  = SW'(SCROLL_DIV - 1);
    localparam logic [AW-1:0] C_POS_LAST = AW'(MSG_LEN - 1);
    // One bit wider so a power-of-two message length is representable
    localparam logic [AW:0]   C_MSG_LEN  = (AW + 1)'(MSG_LEN);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SW-1:0]         sc_q, sc_d;
    logic [AW-1:0]         pos_q, pos_d;
    char_t                 msg_q [MSG_LEN];
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            led_q, led_d;
    logic                  dp_q, dp_d;

    logic [AW:0]           w_sum;
    logic [AW:0]           w_wrap;
    char_t                 w_char;
    logic [6:0]            w_seg;
    logic                  w_lit;

    // Slot timer and digit index advance
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == C_CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Scroll timer runs only in scroll mode; position is frozen otherwise
    always_comb begin
        sc_d  = '0;
        pos_d = pos_q;
        if (mode == MODE_SCROLL) begin
            if (sc_q == C_SC_LAST) begin
                pos_d = (pos_q == C_POS_LAST) ? '0 : pos_q + 1'b1;
            end else begin
                sc_d = sc_q + 1'b1;
            end
        end
    end

    // Character for the current digit; the window index wraps by one subtract
    // since pos < MSG_LEN and idx < NUM_DIGITS <= MSG_LEN
    always_comb begin
        w_sum  = {1'b0, pos_q} + (AW + 1)'(idx_q);
        w_wrap = (w_sum >= C_MSG_LEN) ? (w_sum - C_MSG_LEN) : w_sum;
        if (mode == MODE_SCROLL) begin
            w_char = msg_q[w_wrap[AW-1:0]];
        end else begin
            w_char = dataIn[{idx_q, 2'b00} +: 4];
        end
    end

    seg7_hex_decode u_decode (
        .char_i (w_char),
        .seg_o  (w_seg)
    );

    // Next output pattern: dark during dead time or when the digit is blanked
    always_comb begin
        w_lit = (cnt_q >= C_DEAD) && !blank[idx_q];
        an_d  = w_lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        led_d = w_lit ? w_seg : SEG_BLANK;
        dp_d  = w_lit ? ~dp[idx_q] : 1'b1;
    end

    // Slot and scroll counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            sc_q  <= '0;
            pos_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            sc_q  <= sc_d;
            pos_q <= pos_d;
        end
    end

    // Message store; out-of-range write addresses are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= '0;
            end
        end else if (wrEn && ({1'b0, wrAddr} < C_MSG_LEN)) begin
            msg_q[wrAddr] <= wrData;
        end
    end

    // Output registers, all updated on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= '1;
            led_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            led_q <= led_d;
            dp_q  <= dp_d;
        end
    end

    assign an        = an_q;
    assign LED       = led_q;
    assign dpOut     = dp_q;
    assign scrollPos = pos_q;

endmodule
`default_nettype wire
